keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 113 +++++++++++
 tb/tb_keypad_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 keypad row scanner with 2-flop column sync, press/release debounce and one-cycle key pulses; define KEYPAD_REPEAT_EN for digit auto-repeat
module keypad_scanner #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CYCLES    = 20,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [9:0] button,
  output logic       star,
  output logic       hash,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t st;
  logic [2:0] c1, c2;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [1:0] kcol, ri, ci;
  logic [3:0] kc, kn;
  logic hit, fire, rep;
  always_comb begin
    ri = ~row[0] ? 2'd0 : ~row[1] ? 2'd1 : ~row[2] ? 2'd2 : 2'd3;
    ci = ~c2[0] ? 2'd0 : ~c2[1] ? 2'd1 : 2'd2;
    kn = (ri == 2'd3) ? (ci == 2'd0 ? 4'd10 : ci == 2'd1 ? 4'd0 : 4'd11) : 4'(3 * ri + ci + 1);
    hit = c2[kcol];
    fire = (st == DEBOUNCE && !hit && cnt >= CMAX) || rep;
  end
`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rpt;
  assign rep = st == PRESSED && !hit && rpt == '0 && kc < 4'd10;
  always_ff @(posedge clk)
    if (!rst_n) rpt <= '0;
    else if (st != PRESSED) rpt <= RW'(REPEAT_DELAY - 1);
    else if (!hit) rpt <= (rpt == '0) ? RW'(REPEAT_PERIOD - 1) : rpt - 1'b1;
`else
  logic unused_rpt;
  assign rep = 1'b0;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= SCAN;
      row <= 4'b1110;
      div <= '0;
      cnt <= '0;
      kcol <= '0;
      kc <= '0;
      c1 <= '1;
      c2 <= '1;
      button <= '0;
      star <= 1'b0;
      hash <= 1'b0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
    end else begin
      c1 <= col;
      c2 <= c1;
      button <= (fire && kc < 4'd10) ? 10'd1 << kc : '0;
      star <= fire && kc == 4'd10;
      hash <= fire && kc == 4'd11;
      key_valid <= fire;
      case (st)
        SCAN:
          if (div == DMAX) begin
            div <= '0;
            if (~&c2) begin
              st <= DEBOUNCE;
              kcol <= ci;
              kc <= kn;
              cnt <= '0;
            end else row <= {row[2:0], row[3]};
          end else div <= div + 1'b1;
        DEBOUNCE:
          if (hit) begin
            st <= SCAN;
            cnt <= '0;
            row <= {row[2:0], row[3]};
          end else if (cnt >= CMAX) begin
            st <= PRESSED;
            cnt <= '0;
            key_held <= 1'b1;
          end else cnt <= cnt + 1'b1;
        PRESSED:
          if (hit) begin
            st <= RELEASE;
            cnt <= CW'(1);
          end
        RELEASE:
          if (!hit) begin
            st <= PRESSED;
            cnt <= '0;
          end else if (cnt >= CMAX) begin
            st <= SCAN;
            cnt <= '0;
            key_held <= 1'b0;
            row <= {row[2:0], row[3]};
          end else cnt <= cnt + 1'b1;
        default: st <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, multi-key priority, reset abort and repeat behaviour
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] col;
  logic [3:0] row;
  logic [9:0] button;
  logic star, hash, key_valid, key_held;
  logic [11:0] pk;
  logic [3:0] er;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, kv_n = 0, star_n = 0, hash_n = 0, excl_n = 0;
  int btn_n[10];
  int kv0, st0, hs0, b0, t_acc;
  int q0[$];
  int rep_off[3] = '{50, 70, 90};
  keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8), .REPEAT_DELAY(50), .REPEAT_PERIOD(20)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .button(button),
    .star(star), .hash(hash), .key_valid(key_valid), .key_held(key_held)
  );
  always #5 clk = ~clk;
  always_comb begin
    col = 3'b111;
    for (int i = 0; i < 12; i++) if (pk[i] && !row[i/3]) col[i%3] = 1'b0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    kv_n += int'(key_valid);
    star_n += int'(star);
    hash_n += int'(hash);
    for (int i = 0; i < 10; i++) btn_n[i] += int'(button[i]);
    if ($countones({button, star, hash}) > 1) excl_n++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_row0;
    for (int i = 0; i < 20 && row != 4'b1110; i++) tick();
    chk("wait_row0", 32'(row), 32'(4'b1110));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 10; i++) btn_n[i] = 0;
    pk = '0;
    repeat (3) tick();
    chk("rst_row", 32'(row), 32'(4'b1110));
    chk("rst_outs", 32'({button, star, hash, key_valid, key_held}), 32'd0);
    rst_n = 1'b1;
    kv0 = kv_n;
    for (int k = 1; k <= 20; k++) begin
      tick();
      er = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
      chk($sformatf("scan_row_%0d", k), 32'(row), 32'(er));
    end
    chk("idle_no_pulse", kv_n - kv0, 0);
    pk[4] = 1'b1;
    kv0 = kv_n;
    b0 = btn_n[5];
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 11) chk("k5_early", 32'(key_valid), 32'd0);
      if (k == 12) chk("k5_pulse", 32'({button, star, hash, key_valid, key_held}), 32'({10'b0000100000, 4'b0011}));
    end
    chk("k5_once", btn_n[5] - b0, 1);
    chk("k5_kv_once", kv_n - kv0, 1);
    pk[4] = 1'b0;
    for (int k = 41; k <= 50; k++) begin
      tick();
      if (k == 49) chk("k5_held_hold", 32'(key_held), 32'd1);
      if (k == 50) begin
        chk("k5_held_fall", 32'(key_held), 32'd0);
        chk("k5_next_row", 32'(row), 32'(4'b1011));
      end
    end
    wait_row0();
    kv0 = kv_n;
    tick();
    pk[0] = 1'b1;
    repeat (3) tick();
    pk[0] = 1'b0;
    repeat (2) tick();
    chk("glitch_frozen", 32'(row), 32'(4'b1110));
    tick();
    chk("glitch_resume", 32'(row), 32'(4'b1101));
    chk("glitch_no_pulse", kv_n - kv0, 0);
    pk[9] = 1'b1;
    pk[11] = 1'b1;
    kv0 = kv_n;
    st0 = star_n;
    hs0 = hash_n;
    repeat (40) tick();
    pk = '0;
    repeat (30) tick();
    chk("star_once", star_n - st0, 1);
    chk("hash_never", hash_n - hs0, 0);
    chk("sh_kv_once", kv_n - kv0, 1);
    chk("sh_released", 32'(key_held), 32'd0);
    pk[0] = 1'b1;
    wait_row0();
    kv0 = kv_n;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_row", 32'(row), 32'(4'b1110));
    chk("abort_outs", 32'({button, star, hash, key_valid, key_held}), 32'd0);
    chk("abort_no_pulse", kv_n - kv0, 0);
    rst_n = 1'b1;
    repeat (11) tick();
    chk("redetect_early", 32'(key_valid), 32'd0);
    tick();
    chk("redetect_pulse", 32'({button, star, hash, key_valid, key_held}), 32'({10'b0000000010, 4'b0011}));
    pk = '0;
    repeat (20) tick();
    chk("k1_released", 32'(key_held), 32'd0);
    pk[10] = 1'b1;
    for (int i = 0; i < 40 && !key_valid; i++) tick();
    chk("k0_accept", 32'({button, key_valid}), 32'({10'b0000000001, 1'b1}));
    t_acc = cyc;
    q0.push_back(cyc);
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (button[0]) q0.push_back(cyc);
    end
    pk = '0;
    repeat (20) tick();
    chk("k0_released", 32'(key_held), 32'd0);
`ifdef KEYPAD_REPEAT_EN
    chk("k0_pulse_count", q0.size(), 4);
    for (int i = 1; i <= 3; i++)
      chk($sformatf("k0_repeat_%0d", i), (i < q0.size()) ? q0[i] - t_acc : -1, rep_off[i-1]);
`else
    chk("k0_pulse_count", q0.size(), 1);
`endif
    chk("exclusive", excl_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
